apb_master_bridge: RTL

Request-to-APB master stage that drives the APB bus interface (`paddr`/`prwd`/`pwdata`/`penable`/`psel` out, `prdata`/`pslverr`/`pready` in). It accepts simple valid/ready commands from an on-chip requester and buffers them in a small FIFO. Each command is sequenced through APB SETUP and ACCESS phases. The completed transfer is returned as a single-entry valid/ready response carrying read data and error status.

---
 rtl/apb_master_bridge.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command FIFO feeding an APB master FSM
// (IDLE -> SETUP -> ACCESS), with a single-entry response slot.
// Optional ACCESS watchdog is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int PRDATA_WIDTH   = 32,
  parameter int REQ_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [PADDR_WIDTH-1:0]  req_addr,
  input  logic                    req_write,
  input  logic [PWDATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]              req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PRDATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [PADDR_WIDTH-1:0]  paddr,
  output logic                    prwd,
  output logic [PWDATA_WIDTH-1:0] pwdata,
  output logic                    penable,
  output logic [15:0]             psel,
  input  logic [PRDATA_WIDTH-1:0] prdata,
  input  logic                    pslverr,
  input  logic                    pready
);

  localparam int AW = $clog2(REQ_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0]  addr;
    logic                    write;
    logic [PWDATA_WIDTH-1:0] wdata;
    logic [3:0]              sel;
  } req_t;

  req_t                    mem_q [REQ_DEPTH];
  req_t                    head;
  logic [AW:0]             wr_ptr_q, rd_ptr_q;
  logic                    full, empty, push, pop, done, abort;
  state_t                  state_q, state_d;
  logic [PADDR_WIDTH-1:0]  paddr_q;
  logic                    prwd_q;
  logic [PWDATA_WIDTH-1:0] pwdata_q;
  logic                    penable_q;
  logic [15:0]             psel_q;
  logic                    rsp_valid_q;
  logic [PRDATA_WIDTH-1:0] rsp_rdata_q;
  logic                    rsp_slverr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push      = req_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign req_ready = !full;

  assign paddr      = paddr_q;
  assign prwd       = prwd_q;
  assign pwdata     = pwdata_q;
  assign penable    = penable_q;
  assign psel       = psel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

  // FIFO pointers; reset discards any queued commands.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge pclock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: req_addr, write: req_write,
                                           wdata: req_wdata, sel: req_sel};
  end

  // FSM state register.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state; a transfer only starts when the response slot will be free.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && (!rsp_valid_q || rsp_ready)) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // APB outputs: load on start, penable in ACCESS, drop select on completion.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      paddr_q   <= '0;
      prwd_q    <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
    end else begin
      if (pop) begin
        paddr_q  <= head.addr;
        prwd_q   <= head.write;
        pwdata_q <= head.wdata;
        psel_q   <= 16'h0001 << head.sel;
      end
      if (state_q == SETUP) penable_q <= 1'b1;
      if (done || abort) begin
        psel_q    <= '0;
        penable_q <= 1'b0;
      end
    end
  end

  // Response slot: filled on completion/abort, emptied on handshake.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else if (done || abort) begin
      rsp_valid_q  <= 1'b1;
      rsp_rdata_q  <= (done && !prwd_q) ? prdata : '0;
      rsp_slverr_q <= abort || pslverr;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q;
  logic          rsp_timeout_q;

  // Abort on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign abort       = (state_q == ACCESS) && !pready && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;

  // Watchdog: cleared entering ACCESS, counts wait cycles while in ACCESS.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset)                               tmo_cnt_q <= '0;
    else if (state_q == SETUP)                 tmo_cnt_q <= '0;
    else if (state_q == ACCESS && !pready)     tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  // Timeout flag travels with the response slot contents.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset)            rsp_timeout_q <= 1'b0;
    else if (done || abort) rsp_timeout_q <= abort;
  end
`else
  logic unused_tmo;

  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
`endif

endmodule
